// File: rtl/axonerve_kvs_cmd_issuer.sv
// Host-side command issuer for the Axonerve KVS kernel: credit-limited request
// issue, in-order ACK/opcode pairing, buffered responses and sticky error flags.
module axonerve_kvs_cmd_issuer #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          I_CLK,
   input  logic          I_RST,
   input  logic          I_REQ_VALID,
   output logic          O_REQ_READY,
   input  logic [2:0]    I_REQ_OP,
   input  logic [127:0]  I_REQ_KEY,
   input  logic [127:0]  I_REQ_MSK,
   input  logic [6:0]    I_REQ_PRI,
   input  logic [31:0]   I_REQ_VALUE,
   output logic          O_CMD_VALID,
   output logic          O_CMD_ERASE,
   output logic          O_CMD_WRITE,
   output logic          O_CMD_READ,
   output logic          O_CMD_SEARCH,
   output logic          O_CMD_UPDATE,
   output logic [127:0]  O_KEY_DAT,
   output logic [127:0]  O_EKEY_MSK,
   output logic [6:0]    O_KEY_PRI,
   output logic [31:0]   O_KEY_VALUE,
   input  logic          I_KVS_READY,
   input  logic          I_KVS_WAIT,
   input  logic          I_KVS_CMD_FULL,
   input  logic          I_KVS_ACK,
   input  logic          I_KVS_ENT_ERR,
   input  logic          I_KVS_SINGLE_HIT,
   input  logic          I_KVS_MULTI_HIT,
   input  logic [31:0]   I_KVS_KEY_VALUE,
   input  logic [15:0]   I_KVS_ENT_ADDR,
   output logic          O_RSP_VALID,
   input  logic          I_RSP_READY,
   output logic [2:0]    O_RSP_OP,
   output logic          O_RSP_HIT,
   output logic          O_RSP_MULTI,
   output logic          O_RSP_ERR,
   output logic [31:0]   O_RSP_VALUE,
   output logic [15:0]   O_RSP_ADDR,
   output logic [6:0]    O_IN_FLIGHT,
   output logic          O_TIMEOUT,
   output logic          O_PROTO_ERR
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      WAIT_READY,
      RUN,
      HALT
   } state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic        hit;
      logic        multi;
      logic        err;
      logic [31:0] value;
      logic [15:0] addr;
   } rsp_t;

   state_t         state;
   state_t         state_nxt;

   logic [2:0]     tag_mem [DEPTH];
   logic [AW-1:0]  tag_wr;
   logic [AW-1:0]  tag_rd;

   rsp_t           rsp_mem [DEPTH];
   logic [AW-1:0]  rsp_wr;
   logic [AW-1:0]  rsp_rd;
   logic [CW-1:0]  rsp_count;
   rsp_t           rsp_new;
   rsp_t           rsp_head;

   logic [6:0]     in_flight;
   logic [TW-1:0]  tmo_cnt;
   logic [7:0]     credit_used;

   logic           accept;
   logic           ack_ok;
   logic           ack_bad;
   logic           rsp_pop;
   logic           tmo_hit;

   // Credits cover both in-flight commands and undrained responses, so every
   // ACK always finds a free response slot.
   always_comb begin
      credit_used = {1'b0, in_flight} + 8'(rsp_count);
      O_REQ_READY = (state == RUN) && !I_KVS_WAIT && !I_KVS_CMD_FULL &&
                    (credit_used < 8'(DEPTH));
      accept      = I_REQ_VALID && O_REQ_READY;
      ack_ok      = I_KVS_ACK && (in_flight != '0);
      ack_bad     = I_KVS_ACK && (in_flight == '0);
      O_RSP_VALID = (rsp_count != '0);
      rsp_pop     = O_RSP_VALID && I_RSP_READY;
      tmo_hit     = (in_flight != '0) && (tmo_cnt == TW'(TIMEOUT - 1));
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT_READY: if (I_KVS_READY && !I_KVS_WAIT) state_nxt = RUN;
         RUN:        if (tmo_hit) state_nxt = HALT;
         HALT:       state_nxt = HALT;
         default:    state_nxt = WAIT_READY;
      endcase
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) state <= WAIT_READY;
      else       state <= state_nxt;
   end

   always_comb begin
      rsp_new       = '0;
      rsp_new.op    = tag_mem[tag_rd];
      rsp_new.hit   = I_KVS_SINGLE_HIT || I_KVS_MULTI_HIT;
      rsp_new.multi = I_KVS_MULTI_HIT;
      rsp_new.err   = I_KVS_ENT_ERR;
      rsp_new.value = I_KVS_KEY_VALUE;
      rsp_new.addr  = I_KVS_ENT_ADDR;
   end

   // Storage arrays carry no reset; validity is tracked by pointers/counters.
   always_ff @(posedge I_CLK) begin
      if (accept) tag_mem[tag_wr] <= I_REQ_OP;
      if (ack_ok) rsp_mem[rsp_wr] <= rsp_new;
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         tag_wr      <= '0;
         tag_rd      <= '0;
         rsp_wr      <= '0;
         rsp_rd      <= '0;
         rsp_count   <= '0;
         in_flight   <= '0;
         tmo_cnt     <= '0;
         O_TIMEOUT   <= 1'b0;
         O_PROTO_ERR <= 1'b0;
      end else begin
         if (accept) tag_wr <= tag_wr + 1'b1;
         if (ack_ok) begin
            tag_rd <= tag_rd + 1'b1;
            rsp_wr <= rsp_wr + 1'b1;
         end
         if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;

         unique case ({accept, ack_ok})
            2'b10:   in_flight <= in_flight + 7'd1;
            2'b01:   in_flight <= in_flight - 7'd1;
            default: in_flight <= in_flight;
         endcase

         unique case ({ack_ok, rsp_pop})
            2'b10:   rsp_count <= rsp_count + 1'b1;
            2'b01:   rsp_count <= rsp_count - 1'b1;
            default: rsp_count <= rsp_count;
         endcase

         if (I_KVS_ACK || (in_flight == '0)) tmo_cnt <= '0;
         else                                tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_hit) O_TIMEOUT   <= 1'b1;
         if (ack_bad) O_PROTO_ERR <= 1'b1;
      end
   end

   // Opcode bits are strobes alongside O_CMD_VALID; key fields hold between commands.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         O_CMD_VALID  <= 1'b0;
         O_CMD_SEARCH <= 1'b0;
         O_CMD_WRITE  <= 1'b0;
         O_CMD_ERASE  <= 1'b0;
         O_CMD_UPDATE <= 1'b0;
         O_CMD_READ   <= 1'b0;
         O_KEY_DAT    <= '0;
         O_EKEY_MSK   <= '0;
         O_KEY_PRI    <= '0;
         O_KEY_VALUE  <= '0;
      end else begin
         O_CMD_VALID  <= accept;
         O_CMD_SEARCH <= accept && (I_REQ_OP == 3'd0);
         O_CMD_WRITE  <= accept && (I_REQ_OP == 3'd1);
         O_CMD_ERASE  <= accept && (I_REQ_OP == 3'd2);
         O_CMD_UPDATE <= accept && (I_REQ_OP == 3'd3);
         O_CMD_READ   <= accept && (I_REQ_OP == 3'd4);
         if (accept) begin
            O_KEY_DAT   <= I_REQ_KEY;
            O_EKEY_MSK  <= I_REQ_MSK;
            O_KEY_PRI   <= I_REQ_PRI;
            O_KEY_VALUE <= I_REQ_VALUE;
         end
      end
   end

   always_comb begin
      rsp_head    = O_RSP_VALID ? rsp_mem[rsp_rd] : '0;
      O_RSP_OP    = rsp_head.op;
      O_RSP_HIT   = rsp_head.hit;
      O_RSP_MULTI = rsp_head.multi;
      O_RSP_ERR   = rsp_head.err;
      O_RSP_VALUE = rsp_head.value;
      O_RSP_ADDR  = rsp_head.addr;
      O_IN_FLIGHT = in_flight;
   end

endmodule

// File: tb/tb_axonerve_kvs_cmd_issuer.sv
// Scoreboard bench for axonerve_kvs_cmd_issuer with an auto-ACK kernel stub.
module tb_axonerve_kvs_cmd_issuer;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned TIMEOUT = 16;

   typedef logic [399:0] wide_t;

   logic          I_CLK = 1'b0;
   logic          I_RST = 1'b1;
   logic          I_REQ_VALID = 1'b0;
   logic          O_REQ_READY;
   logic [2:0]    I_REQ_OP = '0;
   logic [127:0]  I_REQ_KEY = '0;
   logic [127:0]  I_REQ_MSK = '0;
   logic [6:0]    I_REQ_PRI = '0;
   logic [31:0]   I_REQ_VALUE = '0;
   logic          O_CMD_VALID, O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE;
   logic [127:0]  O_KEY_DAT, O_EKEY_MSK;
   logic [6:0]    O_KEY_PRI;
   logic [31:0]   O_KEY_VALUE;
   logic          I_KVS_READY = 1'b0;
   logic          I_KVS_WAIT = 1'b1;
   logic          I_KVS_CMD_FULL = 1'b0;
   logic          I_KVS_ACK = 1'b0;
   logic          I_KVS_ENT_ERR = 1'b0;
   logic          I_KVS_SINGLE_HIT = 1'b0;
   logic          I_KVS_MULTI_HIT = 1'b0;
   logic [31:0]   I_KVS_KEY_VALUE = '0;
   logic [15:0]   I_KVS_ENT_ADDR = '0;
   logic          O_RSP_VALID;
   logic          I_RSP_READY = 1'b1;
   logic [2:0]    O_RSP_OP;
   logic          O_RSP_HIT, O_RSP_MULTI, O_RSP_ERR;
   logic [31:0]   O_RSP_VALUE;
   logic [15:0]   O_RSP_ADDR;
   logic [6:0]    O_IN_FLIGHT;
   logic          O_TIMEOUT, O_PROTO_ERR;

   axonerve_kvs_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .I_CLK(I_CLK), .I_RST(I_RST),
      .I_REQ_VALID(I_REQ_VALID), .O_REQ_READY(O_REQ_READY), .I_REQ_OP(I_REQ_OP),
      .I_REQ_KEY(I_REQ_KEY), .I_REQ_MSK(I_REQ_MSK), .I_REQ_PRI(I_REQ_PRI), .I_REQ_VALUE(I_REQ_VALUE),
      .O_CMD_VALID(O_CMD_VALID), .O_CMD_ERASE(O_CMD_ERASE), .O_CMD_WRITE(O_CMD_WRITE),
      .O_CMD_READ(O_CMD_READ), .O_CMD_SEARCH(O_CMD_SEARCH), .O_CMD_UPDATE(O_CMD_UPDATE),
      .O_KEY_DAT(O_KEY_DAT), .O_EKEY_MSK(O_EKEY_MSK), .O_KEY_PRI(O_KEY_PRI), .O_KEY_VALUE(O_KEY_VALUE),
      .I_KVS_READY(I_KVS_READY), .I_KVS_WAIT(I_KVS_WAIT), .I_KVS_CMD_FULL(I_KVS_CMD_FULL),
      .I_KVS_ACK(I_KVS_ACK), .I_KVS_ENT_ERR(I_KVS_ENT_ERR), .I_KVS_SINGLE_HIT(I_KVS_SINGLE_HIT),
      .I_KVS_MULTI_HIT(I_KVS_MULTI_HIT), .I_KVS_KEY_VALUE(I_KVS_KEY_VALUE), .I_KVS_ENT_ADDR(I_KVS_ENT_ADDR),
      .O_RSP_VALID(O_RSP_VALID), .I_RSP_READY(I_RSP_READY), .O_RSP_OP(O_RSP_OP), .O_RSP_HIT(O_RSP_HIT),
      .O_RSP_MULTI(O_RSP_MULTI), .O_RSP_ERR(O_RSP_ERR), .O_RSP_VALUE(O_RSP_VALUE), .O_RSP_ADDR(O_RSP_ADDR),
      .O_IN_FLIGHT(O_IN_FLIGHT), .O_TIMEOUT(O_TIMEOUT), .O_PROTO_ERR(O_PROTO_ERR)
   );

   always #5 I_CLK = ~I_CLK;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [299:0] exp_cmd_q [$];
   logic [2:0]   op_q [$];
   logic [53:0]  exp_rsp_q [$];
   int unsigned  model_if    = 0;
   logic         model_proto = 1'b0;
   int unsigned  accepts     = 0;
   int unsigned  full_acc    = 0;
   int unsigned  rsp_seen    = 0;

   int unsigned  stub_lat  = 3;
   logic         stub_hold = 1'b0;
   int unsigned  man_req   = 0;

   task automatic check(input string tag, input wide_t act, input wide_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Opcode to {erase, write, read, search, update}.
   function automatic logic [4:0] op_hot(input logic [2:0] op);
      case (op)
         3'd0:    op_hot = 5'b00010;
         3'd1:    op_hot = 5'b01000;
         3'd2:    op_hot = 5'b10000;
         3'd3:    op_hot = 5'b00001;
         3'd4:    op_hot = 5'b00100;
         default: op_hot = 5'b00000;
      endcase
   endfunction

   function automatic wide_t reset_bundle();
      reset_bundle = wide_t'({O_REQ_READY, O_CMD_VALID, O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ,
                              O_CMD_SEARCH, O_CMD_UPDATE, O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI,
                              O_KEY_VALUE, O_RSP_VALID, O_RSP_OP, O_RSP_HIT, O_RSP_MULTI,
                              O_RSP_ERR, O_RSP_VALUE, O_RSP_ADDR, O_IN_FLIGHT, O_TIMEOUT,
                              O_PROTO_ERR});
   endfunction

   task automatic monitor();
      logic [2:0] op;
      logic       ack_good;
      logic       acc;
      forever begin
         @(negedge I_CLK);
         if (I_RST) begin
            exp_cmd_q.delete();
            op_q.delete();
            exp_rsp_q.delete();
            model_if    = 0;
            model_proto = 1'b0;
         end else begin
            check("in_flight", wide_t'(O_IN_FLIGHT), wide_t'(model_if));
            check("proto_err", wide_t'(O_PROTO_ERR), wide_t'(model_proto));
            if (O_CMD_VALID) begin
               if (exp_cmd_q.size() == 0)
                  check("cmd_expected", wide_t'(0), wide_t'(1));
               else
                  check("cmd_fields",
                        wide_t'({O_CMD_ERASE, O_CMD_WRITE, O_CMD_READ, O_CMD_SEARCH, O_CMD_UPDATE,
                                 O_KEY_DAT, O_EKEY_MSK, O_KEY_PRI, O_KEY_VALUE}),
                        wide_t'(exp_cmd_q.pop_front()));
            end
            if (O_RSP_VALID && I_RSP_READY) begin
               rsp_seen++;
               if (exp_rsp_q.size() == 0)
                  check("rsp_expected", wide_t'(0), wide_t'(1));
               else
                  check("rsp_fields",
                        wide_t'({O_RSP_OP, O_RSP_HIT, O_RSP_MULTI, O_RSP_ERR, O_RSP_VALUE, O_RSP_ADDR}),
                        wide_t'(exp_rsp_q.pop_front()));
            end
            ack_good = I_KVS_ACK && (model_if != 0);
            if (I_KVS_ACK) begin
               if (ack_good) begin
                  op = op_q.pop_front();
                  exp_rsp_q.push_back({op, I_KVS_SINGLE_HIT | I_KVS_MULTI_HIT, I_KVS_MULTI_HIT,
                                       I_KVS_ENT_ERR, I_KVS_KEY_VALUE, I_KVS_ENT_ADDR});
               end else begin
                  model_proto = 1'b1;
               end
            end
            acc = I_REQ_VALID && O_REQ_READY;
            if (acc) begin
               accepts++;
               if (I_KVS_CMD_FULL) full_acc++;
               exp_cmd_q.push_back({op_hot(I_REQ_OP), I_REQ_KEY, I_REQ_MSK, I_REQ_PRI, I_REQ_VALUE});
               op_q.push_back(I_REQ_OP);
            end
            if (acc && !ack_good)      model_if++;
            else if (!acc && ack_good) model_if--;
         end
      end
   endtask

   // Kernel stub: ACKs each issued command in order after stub_lat cycles unless held.
   task automatic stub();
      longint unsigned pend [$];
      longint unsigned cyc = 0;
      int unsigned     n = 0;
      int unsigned     man_done = 0;
      logic            fire;
      forever begin
         @(posedge I_CLK);
         #1;
         cyc++;
         I_KVS_ACK = 1'b0;
         fire = 1'b0;
         if (I_RST) begin
            pend.delete();
         end else begin
            if (O_CMD_VALID) pend.push_back(cyc);
            if (man_req != man_done) begin
               man_done++;
               fire = 1'b1;
            end else if (!stub_hold && pend.size() != 0 && cyc >= pend[0] + longint'(stub_lat)) begin
               void'(pend.pop_front());
               fire = 1'b1;
            end
            if (fire) begin
               n++;
               I_KVS_ACK        = 1'b1;
               I_KVS_KEY_VALUE  = 32'hA5A5_0000 + n;
               I_KVS_ENT_ADDR   = 16'h0100 + 16'(n);
               I_KVS_SINGLE_HIT = n[0];
               I_KVS_MULTI_HIT  = n[1];
               I_KVS_ENT_ERR    = n[2];
            end
         end
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [127:0] key, input logic [127:0] msk,
                       input logic [6:0] pri, input logic [31:0] val);
      int unsigned n = 0;
      logic        got = 1'b0;
      I_REQ_VALID = 1'b1;
      I_REQ_OP    = op;
      I_REQ_KEY   = key;
      I_REQ_MSK   = msk;
      I_REQ_PRI   = pri;
      I_REQ_VALUE = val;
      while (!got && n < 200) begin
         @(negedge I_CLK);
         got = O_REQ_READY;
         @(posedge I_CLK);
         #1;
         n++;
      end
      I_REQ_VALID = 1'b0;
      if (!got) check("send_accept", wide_t'(0), wide_t'(1));
   endtask

   task automatic drain(input string tag);
      int unsigned n = 0;
      while ((model_if != 0 || exp_rsp_q.size() != 0) && n < 200) begin
         @(posedge I_CLK);
         #1;
         n++;
      end
      check(tag, wide_t'(n < 200), wide_t'(1));
   endtask

   initial begin
      int unsigned a0;
      int unsigned r0;
      int unsigned n;

      fork
         monitor();
         stub();
      join_none

      repeat (3) @(posedge I_CLK);
      #1;
      check("reset_outputs", reset_bundle(), '0);
      I_RST = 1'b0;
      @(posedge I_CLK);
      #1;
      check("ready_kvs_not_ready", wide_t'(O_REQ_READY), wide_t'(0));
      I_KVS_READY = 1'b1;
      I_KVS_WAIT  = 1'b0;
      @(negedge I_CLK);
      check("ready_before_run", wide_t'(O_REQ_READY), wide_t'(0));
      @(posedge I_CLK);
      #1;
      check("ready_rise", wide_t'(O_REQ_READY), wide_t'(1));

      // Single write, ACK after 5 cycles.
      stub_lat = 5;
      r0 = rsp_seen;
      send(3'd1, 128'h1234, '1, 7'h05, 32'h0000_CAFE);
      check("write_strobe", wide_t'({O_CMD_VALID, O_CMD_WRITE}), wide_t'(2'b11));
      @(posedge I_CLK);
      #1;
      check("write_strobe_end", wide_t'({O_CMD_VALID, O_CMD_WRITE}), wide_t'(2'b00));
      check("key_hold", wide_t'({O_KEY_DAT, O_KEY_VALUE}), wide_t'({128'h1234, 32'h0000_CAFE}));
      drain("write_drain");
      check("write_rsp_count", wide_t'(rsp_seen - r0), wide_t'(1));

      // Eight back-to-back searches filling every credit.
      stub_hold   = 1'b1;
      I_RSP_READY = 1'b0;
      a0 = accepts;
      r0 = rsp_seen;
      for (int i = 0; i < 8; i++)
         send(3'd0, {96'd0, 32'h1000 + 32'(i)}, {64'd0, 64'hFFFF_0000 + 64'(i)}, 7'(i), 32'h2000 + 32'(i));
      I_REQ_VALID = 1'b1;
      I_REQ_OP    = 3'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge I_CLK);
         check("ready_credit_full", wide_t'(O_REQ_READY), wide_t'(0));
         @(posedge I_CLK);
         #1;
      end
      I_REQ_VALID = 1'b0;
      check("burst_accepts", wide_t'(accepts - a0), wide_t'(8));
      check("burst_in_flight", wide_t'(O_IN_FLIGHT), wide_t'(8));
      stub_hold = 1'b0;
      n = 0;
      while (model_if != 0 && n < 50) begin
         @(posedge I_CLK);
         #1;
         n++;
      end
      @(posedge I_CLK);
      #1;
      check("burst_acked", wide_t'(O_IN_FLIGHT), wide_t'(0));
      check("ready_rsp_full", wide_t'(O_REQ_READY), wide_t'(0));
      check("rsp_held", wide_t'(rsp_seen - r0), wide_t'(0));
      I_RSP_READY = 1'b1;
      drain("burst_drain");
      check("burst_rsp_count", wide_t'(rsp_seen - r0), wide_t'(8));

      // Command-FIFO full for 10 cycles in the middle of a stream (all opcodes).
      stub_lat = 3;
      a0 = accepts;
      full_acc = 0;
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(3'(i % 8), {32'(i), 96'h0BAD}, {96'd0, 32'(i)}, 7'(7'h40 + i), 32'h3000 + 32'(i));
         end
         begin
            repeat (3) @(posedge I_CLK);
            #1;
            I_KVS_CMD_FULL = 1'b1;
            repeat (10) @(posedge I_CLK);
            #1;
            I_KVS_CMD_FULL = 1'b0;
         end
      join
      drain("full_drain");
      check("full_no_accept", wide_t'(full_acc), wide_t'(0));
      check("full_accepts", wide_t'(accepts - a0), wide_t'(12));

      // Unsolicited ACK.
      r0 = rsp_seen;
      man_req++;
      repeat (3) @(posedge I_CLK);
      #1;
      check("proto_err_set", wide_t'(O_PROTO_ERR), wide_t'(1));
      check("proto_no_rsp", wide_t'({O_RSP_VALID, 32'(rsp_seen - r0)}), wide_t'(0));

      // Timeout with one command outstanding, then a late ACK.
      stub_hold = 1'b1;
      send(3'd4, 128'hFEED, '1, 7'h11, 32'h4444);
      n = 0;
      while (!O_TIMEOUT && n < 40) begin
         @(posedge I_CLK);
         #1;
         n++;
      end
      check("timeout_cycles", wide_t'(n), wide_t'(16));
      check("halt_ready", wide_t'(O_REQ_READY), wide_t'(0));
      r0 = rsp_seen;
      stub_hold = 1'b0;
      drain("late_ack_drain");
      check("late_ack_rsp", wide_t'(rsp_seen - r0), wide_t'(1));
      check("halt_sticky", wide_t'({O_REQ_READY, O_TIMEOUT}), wide_t'(2'b01));

      // Reset recovery, then asynchronous reset with three commands in flight.
      I_RST = 1'b1;
      repeat (2) @(posedge I_CLK);
      #1;
      I_RST = 1'b0;
      check("flags_cleared", wide_t'({O_TIMEOUT, O_PROTO_ERR}), wide_t'(0));
      repeat (2) @(posedge I_CLK);
      #1;
      check("ready_after_reset", wide_t'(O_REQ_READY), wide_t'(1));
      stub_hold = 1'b1;
      send(3'd1, 128'hA1, '1, 7'h01, 32'h11);
      send(3'd2, 128'hA2, '1, 7'h02, 32'h22);
      send(3'd3, 128'hA3, '1, 7'h03, 32'h33);
      repeat (2) @(posedge I_CLK);
      #1;
      check("three_in_flight", wide_t'(O_IN_FLIGHT), wide_t'(3));
      @(negedge I_CLK);
      #2;
      I_RST = 1'b1;
      #1;
      check("async_reset_outputs", reset_bundle(), '0);
      repeat (2) @(posedge I_CLK);
      #1;
      I_RST = 1'b0;
      stub_hold = 1'b0;
      repeat (4) @(posedge I_CLK);
      #1;
      check("post_reset_idle", wide_t'({O_IN_FLIGHT, O_RSP_VALID}), wide_t'(0));
      check("cmd_queue_empty", wide_t'(exp_cmd_q.size()), wide_t'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
